// File: rtl/reg_chain_reader.sv
// reg_chain_reader: drain side of the PE register-file shift chain.
// Takes a snapshot of NWORDS chain words and streams them tail-first
// (idx NWORDS-1 downward) over a valid/ready interface, one word per handshake.
// Optional build macro REG_CHAIN_READER_PARITY_EN adds o_out_parity (even
// parity of o_out_data, registered alongside it).
//
// state  | meaning
// S_IDLE | ready for a snapshot (o_snap_ready=1 outside reset)
// S_SEND | presenting buffered words, waiting on o_out_valid & i_out_ready
module reg_chain_reader #(
  parameter int DW     = 32,
  parameter int NWORDS = 4,
  parameter int LW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_snap_valid,
  output logic                 o_snap_ready,
  input  logic [DW*NWORDS-1:0] i_snap_data,
  input  logic [LW-1:0]        i_snap_len,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [DW-1:0]        o_out_data,
  output logic [LW-1:0]        o_out_idx,
  output logic                 o_out_last,
  output logic                 o_busy
`ifdef REG_CHAIN_READER_PARITY_EN
  ,
  output logic                 o_out_parity
`endif
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [LW-1:0] C_NWORDS = LW'(NWORDS);
  localparam logic [LW-1:0] C_TAIL   = LW'(NWORDS - 1);
  localparam logic [LW-1:0] C_ONE    = LW'(1);
  localparam logic [LW-1:0] C_TWO    = LW'(2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW*NWORDS-1:0]  r_buf;
  logic [LW-1:0]         r_cnt;
  logic [LW-1:0]         r_idx;
  logic                  r_out_valid;
  logic [DW-1:0]         r_out_data;
  logic                  r_out_last;
  logic                  r_out_parity;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_xfer;
  logic                  w_final;
  logic [LW-1:0]         w_len;
  logic [LW-1:0]         w_idx_dec;
  logic [DW-1:0]         w_word_dec;
  logic [DW-1:0]         w_tail_word;

  assign o_snap_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept     = i_snap_valid & o_snap_ready;
  assign w_len        = (i_snap_len > C_NWORDS) ? C_NWORDS : i_snap_len;
  // A zero-length snapshot is consumed but never loads the output stage.
  assign w_load       = w_accept & (w_len != '0);
  assign w_xfer       = r_out_valid & i_out_ready;
  assign w_final      = (r_cnt == C_ONE);
  assign w_idx_dec    = r_idx - C_ONE;
  // Only consumed when not final, so r_idx >= 1 and the select stays in range.
  assign w_word_dec   = r_buf[int'(w_idx_dec)*DW +: DW];
  // The first word bypasses the buffer since the buffer loads on the same edge.
  assign w_tail_word  = i_snap_data[(NWORDS-1)*DW +: DW];

  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_idx    = r_idx;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state == S_SEND);
`ifdef REG_CHAIN_READER_PARITY_EN
  assign o_out_parity = r_out_parity;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: load on a non-empty snapshot, leave after the final transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_SEND;
      S_SEND:  if (w_xfer && w_final) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot buffer, written only when a snapshot is accepted.
  always_ff @(posedge clk) begin
    if (rst)           r_buf <= '0;
    else if (w_accept) r_buf <= i_snap_data;
  end

  // Output stage and word counters; everything holds during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_parity <= 1'b0;
    end else if (w_load) begin
      r_cnt        <= w_len;
      r_idx        <= C_TAIL;
      r_out_valid  <= 1'b1;
      r_out_data   <= w_tail_word;
      r_out_last   <= (w_len == C_ONE);
      r_out_parity <= ^w_tail_word;
    end else if (w_xfer) begin
      if (w_final) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        r_cnt        <= r_cnt - C_ONE;
        r_idx        <= w_idx_dec;
        r_out_data   <= w_word_dec;
        r_out_last   <= (r_cnt == C_TWO);
        r_out_parity <= ^w_word_dec;
      end
    end
  end

endmodule

// File: tb/tb_reg_chain_reader.sv
// Directed bench for reg_chain_reader: a cycle table for streaming, stalls and
// length clamping, then hand sequences for busy back-pressure, mid-drain reset
// and (when built with REG_CHAIN_READER_PARITY_EN) parity.
module tb_reg_chain_reader;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int LW = 5;

  logic             clk;
  logic             rst;
  logic             snap_valid;
  logic             snap_ready;
  logic [DW*NW-1:0] snap_data;
  logic [LW-1:0]    snap_len;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LW-1:0]    out_idx;
  logic             out_last;
  logic             busy;
`ifdef REG_CHAIN_READER_PARITY_EN
  logic             out_parity;
`endif

  int checks = 0;
  int errors = 0;

  reg_chain_reader #(.DW(DW), .NWORDS(NW), .LW(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_snap_valid (snap_valid),
    .o_snap_ready (snap_ready),
    .i_snap_data  (snap_data),
    .i_snap_len   (snap_len),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_idx    (out_idx),
    .o_out_last   (out_last),
    .o_busy       (busy)
`ifdef REG_CHAIN_READER_PARITY_EN
    ,
    .o_out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sv;
    logic [4:0]  len;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_idx;
    logic        e_last;
    logic        e_busy;
    logic        e_sready;
  } vec_t;

  localparam logic [DW*NW-1:0] D_ORIG = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [DW*NW-1:0] D_AA   = {32'hAAAAAAA3, 32'hAAAAAAA2, 32'hAAAAAAA1, 32'hAAAAAAA0};
  localparam logic [DW*NW-1:0] D_NEW  = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sv len rdy | valid data idx last busy sready
    // test 1: full drain, out_ready=1
    vecs[0]  = '{1'b1, 5'd4, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h44444444, 5'd3, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h33333333, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h22222222, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h11111111, 5'd0, 1'b1, 1'b1, 1'b0};
    // test 2: ready pattern 1,0,0,1,0,1,1
    vecs[5]  = '{1'b1, 5'd4, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h44444444, 5'd3, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd4, 1'b0, 1'b1, 32'h33333333, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 5'd4, 1'b0, 1'b1, 32'h33333333, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h33333333, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 5'd4, 1'b0, 1'b1, 32'h22222222, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h22222222, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd4, 1'b1, 1'b1, 32'h11111111, 5'd0, 1'b1, 1'b1, 1'b0};
    // test 3: len=2, len=0, len=9
    vecs[13] = '{1'b1, 5'd2, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 5'd2, 1'b1, 1'b1, 32'h44444444, 5'd3, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 5'd2, 1'b1, 1'b1, 32'h33333333, 5'd2, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 5'd0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 5'd9, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 5'd9, 1'b1, 1'b1, 32'h44444444, 5'd3, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 5'd9, 1'b1, 1'b1, 32'h33333333, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 5'd9, 1'b1, 1'b1, 32'h22222222, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 5'd9, 1'b1, 1'b1, 32'h11111111, 5'd0, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 5'd0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1};

    rst        = 1'b1;
    snap_valid = 1'b0;
    snap_data  = D_ORIG;
    snap_len   = '0;
    out_ready  = 1'b0;
    tick(); tick(); tick();

    // reset state
    chk("rst_sready", 32'(snap_ready), 32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_data",   out_data,        32'd0);
    chk("rst_idx",    32'(out_idx),    32'd0);
    chk("rst_last",   32'(out_last),   32'd0);
    rst = 1'b0;
    #1;
    chk("rel_sready", 32'(snap_ready), 32'd1);

    // table: tests 1..3
    for (int i = 0; i < 23; i++) begin
      snap_valid = vecs[i].sv;
      snap_len   = vecs[i].len;
      out_ready  = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i),  32'(out_valid),  32'(vecs[i].e_valid));
      chk($sformatf("v%0d_busy", i),   32'(busy),       32'(vecs[i].e_busy));
      chk($sformatf("v%0d_sready", i), 32'(snap_ready), 32'(vecs[i].e_sready));
      chk($sformatf("v%0d_last", i),   32'(out_last),   32'(vecs[i].e_last));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_data", i), out_data,       vecs[i].e_data);
        chk($sformatf("v%0d_idx", i),  32'(out_idx),   32'(vecs[i].e_idx));
      end
      tick();
    end

    // test 4: snapshot offered while busy is held off until after the final transfer
    snap_valid = 1'b1;
    snap_len   = 5'd4;
    snap_data  = D_ORIG;
    out_ready  = 1'b1;
    tick();
    snap_data = D_AA;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_hold_data%0d", k), out_data, 32'h11111111 * (4 - k));
      chk($sformatf("t4_hold_sready%0d", k), 32'(snap_ready), 32'd0);
      tick();
    end
    chk("t4_gap_valid",  32'(out_valid),  32'd0);
    chk("t4_gap_sready", 32'(snap_ready), 32'd1);
    tick();
    snap_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_aa_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("t4_aa_data%0d", k),  out_data, 32'hAAAAAAA3 - 32'(k));
      chk($sformatf("t4_aa_idx%0d", k),   32'(out_idx), 32'(3 - k));
      tick();
    end
    chk("t4_end_valid", 32'(out_valid), 32'd0);

    // test 5: reset one cycle after the second transfer
    snap_valid = 1'b1;
    snap_len   = 5'd4;
    snap_data  = D_ORIG;
    tick();
    snap_valid = 1'b0;
    chk("t5_w0", out_data, 32'h44444444);
    tick();
    chk("t5_w1", out_data, 32'h33333333);
    tick();
    chk("t5_w2", out_data, 32'h22222222);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid",  32'(out_valid),  32'd0);
    chk("t5_rst_busy",   32'(busy),       32'd0);
    chk("t5_rst_sready", 32'(snap_ready), 32'd0);
    chk("t5_rst_idx",    32'(out_idx),    32'd0);
    rst = 1'b0;
    #1;
    chk("t5_rel_sready", 32'(snap_ready), 32'd1);
    snap_valid = 1'b1;
    snap_data  = D_NEW;
    tick();
    snap_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_new_data%0d", k), out_data, 32'h55550003 - 32'(k));
      chk($sformatf("t5_new_idx%0d", k),  32'(out_idx), 32'(3 - k));
      chk($sformatf("t5_new_last%0d", k), 32'(out_last), 32'(k == 3));
      tick();
    end
    chk("t5_end_busy", 32'(busy), 32'd0);

`ifdef REG_CHAIN_READER_PARITY_EN
    // test 6: parity of 0x00000001 then 0x00000003
    snap_valid = 1'b1;
    snap_len   = 5'd2;
    snap_data  = {32'h00000001, 32'h00000003, 32'h0, 32'h0};
    tick();
    snap_valid = 1'b0;
    chk("t6_par1", 32'(out_parity), 32'd1);
    tick();
    chk("t6_par0", 32'(out_parity), 32'd0);
    chk("t6_last", 32'(out_last),   32'd1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
